// File: rtl/data_route.sv
// data_route: routes each input word into one of two independent 2-entry output queues (A/B); define DATA_ROUTE_BROADCAST_EN to add a broadcast input that pushes into both.

module data_route_q #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           push,
  input  logic           ready,
  input  logic [WIDTH:1] din,
  output logic           valid,
  output logic           full,
  output logic [WIDTH:1] dout
);
  logic [1:0]     cnt;
  logic [WIDTH:1] head;
  logic [WIDTH:1] tail;
  logic           pop;
  // queue status flags and head presentation
  always_comb begin
    valid = cnt != 2'd0;
    full  = cnt == 2'(DEPTH);
    pop   = valid && ready;
    dout  = head;
  end
  // head/tail storage; head is cleared when the queue drains so dout reads 0 while empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (push && !pop) begin
      cnt <= cnt + 2'd1;
      if (cnt == 2'd0) head <= din;
      else tail <= din;
    end else if (pop && !push) begin
      cnt  <= cnt - 2'd1;
      head <= (cnt == 2'd2) ? tail : '0;
      tail <= '0;
    end else if (push && pop) begin
      head <= din;
    end
  end
endmodule

module data_route #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [WIDTH:1] in_data,
  input  logic           select_code,
`ifdef DATA_ROUTE_BROADCAST_EN
  input  logic           broadcast,
`endif
  output logic           outA_valid,
  input  logic           outA_ready,
  output logic [WIDTH:1] outA_data,
  output logic           outB_valid,
  input  logic           outB_ready,
  output logic [WIDTH:1] outB_data
);
  logic bc;
  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;
  // acceptance ignores same-cycle pops; broadcast needs room in both queues
  always_comb begin
`ifdef DATA_ROUTE_BROADCAST_EN
    bc = broadcast;
`else
    bc = 1'b0;
`endif
    in_ready = bc ? (!full_a && !full_b) : (select_code ? !full_b : !full_a);
    push_a   = in_valid && in_ready && (bc || !select_code);
    push_b   = in_valid && in_ready && (bc || select_code);
  end

  data_route_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_qa (
    .clk(clk), .rst_n(rst_n), .push(push_a), .ready(outA_ready), .din(in_data),
    .valid(outA_valid), .full(full_a), .dout(outA_data)
  );

  data_route_q #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_qb (
    .clk(clk), .rst_n(rst_n), .push(push_b), .ready(outB_ready), .din(in_data),
    .valid(outB_valid), .full(full_b), .dout(outB_data)
  );
endmodule

// File: tb/tb_data_route.sv
// tb_data_route: directed-vector bench for data_route (add DATA_ROUTE_BROADCAST_EN for the broadcast scenario).
module tb_data_route;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [32:1] in_data = '0;
  logic        select_code = 1'b0;
  logic        broadcast = 1'b0;
  logic        outA_valid, outA_ready = 1'b0;
  logic [32:1] outA_data;
  logic        outB_valid, outB_ready = 1'b0;
  logic [32:1] outB_data;
  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  data_route #(.WIDTH(32), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .select_code(select_code),
`ifdef DATA_ROUTE_BROADCAST_EN
    .broadcast(broadcast),
`endif
    .outA_valid(outA_valid), .outA_ready(outA_ready), .outA_data(outA_data),
    .outB_valid(outB_valid), .outB_ready(outB_ready), .outB_data(outB_data)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    nvec++; if (outA_valid !== 1'b0) begin nerr++; $display("FAIL rst_a_valid got %b want 0", outA_valid); end
    nvec++; if (outB_valid !== 1'b0) begin nerr++; $display("FAIL rst_b_valid got %b want 0", outB_valid); end
    nvec++; if (outA_data !== 32'h0) begin nerr++; $display("FAIL rst_a_data got %h want 0", outA_data); end
    nvec++; if (outB_data !== 32'h0) begin nerr++; $display("FAIL rst_b_data got %h want 0", outB_data); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = 32'hDEAD0001;
    step();
    nvec++; if (outA_valid !== 1'b0) begin nerr++; $display("FAIL rst_no_xfer got %b want 0", outA_valid); end
    in_valid = 1'b0;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_route();
    outA_ready = 1'b1; outB_ready = 1'b1;
    in_valid = 1'b1; select_code = 1'b0; in_data = 32'h11111111;
    step();
    nvec++; if (outA_valid !== 1'b1 || outA_data !== 32'h11111111) begin nerr++; $display("FAIL route_a got %b/%h want 1/11111111", outA_valid, outA_data); end
    nvec++; if (outB_valid !== 1'b0) begin nerr++; $display("FAIL route_a_not_b got %b want 0", outB_valid); end
    select_code = 1'b1; in_data = 32'h22222222;
    step();
    nvec++; if (outA_valid !== 1'b0 || outA_data !== 32'h0) begin nerr++; $display("FAIL route_a_pop got %b/%h want 0/0", outA_valid, outA_data); end
    nvec++; if (outB_valid !== 1'b1 || outB_data !== 32'h22222222) begin nerr++; $display("FAIL route_b got %b/%h want 1/22222222", outB_valid, outB_data); end
    in_valid = 1'b0;
    step();
    nvec++; if (outB_valid !== 1'b0) begin nerr++; $display("FAIL route_b_pop got %b want 0", outB_valid); end
  endtask

  task automatic test_full();
    outA_ready = 1'b0; outB_ready = 1'b0;
    in_valid = 1'b1; select_code = 1'b0; in_data = 32'hA1;
    step();
    in_data = 32'hA2;
    step();
    in_valid = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL full_ready_a got %b want 0", in_ready); end
    select_code = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL full_ready_b got %b want 1", in_ready); end
    in_valid = 1'b1; in_data = 32'hB1;
    step();
    in_valid = 1'b0;
    nvec++; if (outB_valid !== 1'b1 || outB_data !== 32'hB1) begin nerr++; $display("FAIL full_b_pass got %b/%h want 1/b1", outB_valid, outB_data); end
    nvec++; if (outA_valid !== 1'b1 || outA_data !== 32'hA1) begin nerr++; $display("FAIL full_a_hold got %b/%h want 1/a1", outA_valid, outA_data); end
    outB_ready = 1'b1;
    step();
    outB_ready = 1'b0;
    nvec++; if (outB_valid !== 1'b0 || outB_data !== 32'h0) begin nerr++; $display("FAIL full_b_drain got %b/%h want 0/0", outB_valid, outB_data); end
  endtask

  task automatic test_full_pop();
    outA_ready = 1'b1; in_valid = 1'b1; select_code = 1'b0; in_data = 32'hA3;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL fpop_refuse got %b want 0", in_ready); end
    step();
    nvec++; if (outA_data !== 32'hA2) begin nerr++; $display("FAIL fpop_head got %h want a2", outA_data); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL fpop_ready got %b want 1", in_ready); end
    outA_ready = 1'b0;
    step();
    in_valid = 1'b0;
    nvec++; if (outA_data !== 32'hA2 || in_ready !== 1'b0) begin nerr++; $display("FAIL fpop_accept got %h/%b want a2/0", outA_data, in_ready); end
    outA_ready = 1'b1;
    step();
    nvec++; if (outA_valid !== 1'b1 || outA_data !== 32'hA3) begin nerr++; $display("FAIL fpop_order got %b/%h want 1/a3", outA_valid, outA_data); end
    step();
    nvec++; if (outA_valid !== 1'b0 || outA_data !== 32'h0) begin nerr++; $display("FAIL fpop_empty got %b/%h want 0/0", outA_valid, outA_data); end
    outA_ready = 1'b0;
  endtask

  task automatic test_concurrent();
    in_valid = 1'b1; select_code = 1'b0; in_data = 32'hA1;
    step();
    outA_ready = 1'b1; in_data = 32'hA2;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL conc_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0; outA_ready = 1'b0;
    nvec++; if (outA_valid !== 1'b1 || outA_data !== 32'hA2) begin nerr++; $display("FAIL conc_head got %b/%h want 1/a2", outA_valid, outA_data); end
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL conc_one got %b want 1", in_ready); end
    outA_ready = 1'b1;
    step();
    outA_ready = 1'b0;
    nvec++; if (outA_valid !== 1'b0) begin nerr++; $display("FAIL conc_drain got %b want 0", outA_valid); end
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; select_code = 1'b0; in_data = 32'hC1;
    step();
    in_data = 32'hC2;
    step();
    select_code = 1'b1; in_data = 32'hD1;
    step();
    in_data = 32'hD2;
    step();
    in_valid = 1'b0;
    nvec++; if (outA_valid !== 1'b1 || outB_valid !== 1'b1 || in_ready !== 1'b0) begin nerr++; $display("FAIL mid_fill got %b%b%b want 110", outA_valid, outB_valid, in_ready); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (outA_valid !== 1'b0 || outB_valid !== 1'b0) begin nerr++; $display("FAIL mid_async_valid got %b%b want 00", outA_valid, outB_valid); end
    nvec++; if (outA_data !== 32'h0 || outB_data !== 32'h0 || in_ready !== 1'b1) begin nerr++; $display("FAIL mid_async_data got %h/%h/%b want 0/0/1", outA_data, outB_data, in_ready); end
    step();
    rst_n = 1'b1;
    in_valid = 1'b1; select_code = 1'b0; in_data = 32'hE1;
    step();
    in_valid = 1'b0;
    nvec++; if (outA_valid !== 1'b1 || outA_data !== 32'hE1) begin nerr++; $display("FAIL mid_first got %b/%h want 1/e1", outA_valid, outA_data); end
    outA_ready = 1'b1;
    step();
    outA_ready = 1'b0;
    nvec++; if (outA_valid !== 1'b0 || outB_valid !== 1'b0) begin nerr++; $display("FAIL mid_alone got %b%b want 00", outA_valid, outB_valid); end
  endtask

`ifdef DATA_ROUTE_BROADCAST_EN
  task automatic test_broadcast();
    broadcast = 1'b1; select_code = 1'b1; in_valid = 1'b1; in_data = 32'hCAFEF00D;
    step();
    in_valid = 1'b0;
    nvec++; if (outA_data !== 32'hCAFEF00D || outB_data !== 32'hCAFEF00D) begin nerr++; $display("FAIL bc_both got %h/%h want cafef00d", outA_data, outB_data); end
    broadcast = 1'b0; in_valid = 1'b1; in_data = 32'h1;
    step();
    in_valid = 1'b0; broadcast = 1'b1;
    #1;
    nvec++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL bc_b_full got %b want 0", in_ready); end
    broadcast = 1'b0; select_code = 1'b0;
    #1;
    nvec++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL bc_off_a got %b want 1", in_ready); end
    outA_ready = 1'b1; outB_ready = 1'b1;
    step(); step();
    outA_ready = 1'b0; outB_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_route();
    test_full();
    test_full_pop();
    test_concurrent();
    test_reset_mid();
`ifdef DATA_ROUTE_BROADCAST_EN
    test_broadcast();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
